// File: rtl/calc_kbd_pkg.sv
// ----------------------------------------------------------------------------
// calc_kbd_pkg
// Shared constants for the calculator keypad: matrix geometry, named key
// indices (index = 5*(row-1) + column) and a lowest-index priority helper.
// ----------------------------------------------------------------------------
package calc_kbd_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 5;
    localparam int NUM_KEYS = 20;

    localparam int KEY_0      = 15;
    localparam int KEY_1      = 5;
    localparam int KEY_AC     = 3;
    localparam int KEY_CE     = 4;
    localparam int KEY_PLUS   = 13;
    localparam int KEY_MINUS  = 8;
    localparam int KEY_MUL    = 14;
    localparam int KEY_DIV    = 9;
    localparam int KEY_SQUARE = 17;
    localparam int KEY_EQUAL  = 19;

    // Index of the lowest set bit, 0 when none is set.
    function automatic logic [4:0] first_key(input logic [NUM_KEYS-1:0] keys);
        logic [4:0] idx;
        idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (keys[k]) idx = 5'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// Debouncer for a single key. The debounced state only changes after
// DEBOUNCE consecutive samples that disagree with it; a change to "pressed"
// produces a one-cycle registered pulse. Releases are silent.
//
// Ports:
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_sample_en this key's sampling instant
//   i_sample    sampled key level, 1 = pressed
//   o_fire      combinational: the pulse that will be registered this edge
//   o_pulse     registered one-cycle press pulse
// ----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sample_en,
    input  logic i_sample,
    output logic o_fire,
    output logic o_pulse
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] r_cnt;
    logic          r_stable;
    logic          r_pulse;
    logic          w_differs;
    logic          w_flip;

    assign w_differs = i_sample_en && (i_sample != r_stable);
    assign w_flip    = w_differs && (r_cnt == CW'(DEBOUNCE - 1));
    assign o_fire    = w_flip && i_sample;
    assign o_pulse   = r_pulse;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_pulse <= o_fire;
            if (i_sample_en) begin
                if (!w_differs) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_stable <= i_sample;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_key_scanner.sv
// ----------------------------------------------------------------------------
// calc_key_scanner
// 4x5 matrix keypad scanner: drives one row low at a time for SCAN_DIV
// cycles, samples the synchronized columns on the last cycle of each slot,
// debounces each key and emits one-cycle press pulses per row.
//
// Ports:
//   sys_clk            system clock
//   rst                synchronous active-high reset
//   key_row_n[3:0]     row drive, active-low, bit 0 = row1
//   key_col_n[4:0]     column sense, active-low, asynchronous
//   input_row1..4[4:0] press pulses, bit c = column c of that row
//   key_valid          any press pulse high
//   key_code[4:0]      5*(row-1)+col of lowest pulsing key, else 0
// ----------------------------------------------------------------------------
module calc_key_scanner
    import calc_kbd_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic       sys_clk,
    input  logic       rst,
    output logic [3:0] key_row_n,
    input  logic [4:0] key_col_n,
    output logic [4:0] input_row1,
    output logic [4:0] input_row2,
    output logic [4:0] input_row3,
    output logic [4:0] input_row4,
    output logic       key_valid,
    output logic [4:0] key_code
);

    localparam int SW = $clog2(SCAN_DIV);

    logic [SW-1:0]       r_slot;
    logic [1:0]          r_row;
    logic [3:0]          r_row_n;
    logic [4:0]          r_col_meta;
    logic [4:0]          r_col_sync;
    logic                r_valid;
    logic [4:0]          r_code;

    logic                w_slot_end;
    logic [1:0]          w_row_next;
    logic [NUM_ROWS-1:0] w_row_en;
    logic [NUM_KEYS-1:0] w_fire;
    logic [NUM_KEYS-1:0] w_pulse;

    assign w_slot_end = (r_slot == SW'(SCAN_DIV - 1));
    assign w_row_next = w_slot_end ? r_row + 2'd1 : r_row;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_slot     <= '0;
            r_row      <= 2'd0;
            r_row_n    <= 4'b1110;
            r_col_meta <= 5'b11111;
            r_col_sync <= 5'b11111;
            r_valid    <= 1'b0;
            r_code     <= 5'd0;
        end else begin
            r_slot     <= w_slot_end ? '0 : r_slot + 1'b1;
            r_row      <= w_row_next;
            // Row drive is registered from the next row index so it stays
            // aligned with r_row without a decode after the flop.
            r_row_n    <= ~(4'b0001 << w_row_next);
            r_col_meta <= key_col_n;
            r_col_sync <= r_col_meta;
            // Registered from the same fire vector as the per-key pulses,
            // so valid/code line up with input_rowN in the same cycle.
            r_valid    <= |w_fire;
            r_code     <= first_key(w_fire);
        end
    end

    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        assign w_row_en[r] = w_slot_end && (r_row == 2'(r));
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            key_debounce #(
                .DEBOUNCE (int'(DEBOUNCE))
            ) u_key (
                .i_clk       (sys_clk),
                .i_rst       (rst),
                .i_sample_en (w_row_en[r]),
                .i_sample    (~r_col_sync[c]),
                .o_fire      (w_fire[r*NUM_COLS+c]),
                .o_pulse     (w_pulse[r*NUM_COLS+c])
            );
        end
    end

    assign key_row_n  = r_row_n;
    assign input_row1 = w_pulse[4:0];
    assign input_row2 = w_pulse[9:5];
    assign input_row3 = w_pulse[14:10];
    assign input_row4 = w_pulse[19:15];
    assign key_valid  = r_valid;
    assign key_code   = r_code;

endmodule

// File: tb/tb_calc_key_scanner.sv
// ----------------------------------------------------------------------------
// tb_calc_key_scanner
// Directed bench for calc_key_scanner with SCAN_DIV=4, DEBOUNCE=3. A keypad
// model shorts pressed keys onto the columns of the driven row; a monitor
// counts pulse cycles per key and cross-checks key_valid/key_code.
// ----------------------------------------------------------------------------
module tb_calc_key_scanner;
    import calc_kbd_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    logic       sys_clk = 1'b0;
    logic       rst     = 1'b1;
    logic [3:0] key_row_n;
    logic [4:0] key_col_n;
    logic [4:0] input_row1;
    logic [4:0] input_row2;
    logic [4:0] input_row3;
    logic [4:0] input_row4;
    logic       key_valid;
    logic [4:0] key_code;

    logic [19:0] pressed = '0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          total    = 0;
    int          pcnt[20] = '{default: 0};
    int          last_cyc = 0;
    logic [19:0] last_vec = '0;
    logic [4:0]  last_code = '0;
    logic [19:0] mon_vec;

    always #5 sys_clk = ~sys_clk;

    // Keypad: a pressed key pulls its column low while its row is driven low.
    always_comb begin
        key_col_n = 5'b11111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (pressed[r*5+c] && (key_row_n[r] == 1'b0)) key_col_n[c] = 1'b0;
            end
        end
    end

    calc_key_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .key_row_n  (key_row_n),
        .key_col_n  (key_col_n),
        .input_row1 (input_row1),
        .input_row2 (input_row2),
        .input_row3 (input_row3),
        .input_row4 (input_row4),
        .key_valid  (key_valid),
        .key_code   (key_code)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [19:0] v);
        for (int k = 0; k < 20; k++) begin
            if (v[k]) return k;
        end
        return 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_pulse(input int key, input int base, input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (pcnt[key] > base) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        if (pcnt[key] > base) seen = 1'b1;
    endtask

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        mon_vec = {input_row4, input_row3, input_row2, input_row1};
        if (mon_vec != 20'd0) begin
            for (int k = 0; k < 20; k++) begin
                if (mon_vec[k]) begin
                    pcnt[k]++;
                    total++;
                end
            end
            last_cyc  = cyc;
            last_vec  = mon_vec;
            last_code = key_code;
            check_eq("mon_valid", {31'd0, key_valid}, 32'd1);
            check_eq("mon_code", {27'd0, key_code}, lowest(mon_vec));
        end else begin
            check_eq("mon_idle", {26'd0, key_valid, key_code}, 32'd0);
        end
    end

    initial begin
        bit         seen;
        int         base;
        int         base2;
        int         press_cyc;
        int         lat;
        logic [3:0] exp_row;

        // Reset and idle scanning.
        rst = 1'b1;
        tick(3);
        check_eq("rst_row_n", {28'd0, key_row_n}, 32'he);
        check_eq("rst_rows", {12'd0, input_row4, input_row3, input_row2, input_row1}, 32'd0);
        check_eq("rst_valid", {31'd0, key_valid}, 32'd0);
        check_eq("rst_code", {27'd0, key_code}, 32'd0);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            exp_row = ~(4'b0001 << ((k / 4) % 4));
            check_eq("row_drive", {28'd0, key_row_n}, {28'd0, exp_row});
        end
        tick(484);
        check_eq("idle_pulses", total, 0);

        // Clean press of KEY_PLUS; latency measured from synchronizer output.
        base      = pcnt[KEY_PLUS];
        press_cyc = cyc;
        pressed[KEY_PLUS] = 1'b1;
        wait_pulse(KEY_PLUS, base, 80, seen);
        check_eq("plus_seen", {31'd0, seen}, 32'd1);
        lat = last_cyc - press_cyc - 2;
        check_eq("plus_latency", {31'd0, (lat >= 33 && lat <= 49)}, 32'd1);
        check_eq("plus_vec", last_vec, 32'd1 << KEY_PLUS);
        check_eq("plus_code", last_code, 32'd13);
        tick(60);
        check_eq("plus_count", pcnt[KEY_PLUS] - base, 1);
        pressed = '0;
        tick(64);

        // Bouncing KEY_EQUAL: no pulse until held, then one; re-press gives another.
        base = pcnt[KEY_EQUAL];
        for (int i = 0; i < 12; i++) begin
            pressed[KEY_EQUAL] = (i % 2 == 0);
            tick(5);
        end
        check_eq("eq_bounce", pcnt[KEY_EQUAL] - base, 0);
        pressed[KEY_EQUAL] = 1'b1;
        wait_pulse(KEY_EQUAL, base, 80, seen);
        check_eq("eq_seen", {31'd0, seen}, 32'd1);
        check_eq("eq_code", last_code, 32'd19);
        check_eq("eq_vec", last_vec, 32'd1 << KEY_EQUAL);
        tick(60);
        check_eq("eq_count", pcnt[KEY_EQUAL] - base, 1);
        pressed[KEY_EQUAL] = 1'b0;
        tick(64);
        check_eq("eq_release", pcnt[KEY_EQUAL] - base, 1);
        pressed[KEY_EQUAL] = 1'b1;
        wait_pulse(KEY_EQUAL, base + 1, 80, seen);
        check_eq("eq_repress", {31'd0, seen}, 32'd1);
        check_eq("eq_count2", pcnt[KEY_EQUAL] - base, 2);
        pressed = '0;
        tick(64);

        // Two keys of row2 pressed together pulse in the same cycle.
        base  = pcnt[6];
        base2 = pcnt[9];
        pressed[6] = 1'b1;
        pressed[9] = 1'b1;
        wait_pulse(6, base, 80, seen);
        check_eq("pair_seen", {31'd0, seen}, 32'd1);
        check_eq("pair_vec", last_vec, (32'd1 << 6) | (32'd1 << 9));
        check_eq("pair_code", last_code, 32'd6);
        tick(20);
        check_eq("pair_count9", pcnt[9] - base2, 1);
        pressed = '0;
        tick(64);

        // Reset while KEY_1 has two matching samples (cnt=2).
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        pressed[KEY_1] = 1'b1;
        base = pcnt[KEY_1];
        tick(30);
        rst = 1'b1;
        tick(1);
        check_eq("midrst_rows", {12'd0, input_row4, input_row3, input_row2, input_row1}, 32'd0);
        check_eq("midrst_row_n", {28'd0, key_row_n}, 32'he);
        check_eq("midrst_none", pcnt[KEY_1] - base, 0);
        rst = 1'b0;
        // Post-reset samples of row2 land on edges 8, 24 and 40.
        tick(39);
        check_eq("key1_early", pcnt[KEY_1] - base, 0);
        tick(1);
        check_eq("key1_pulse", pcnt[KEY_1] - base, 1);
        pressed = '0;
        tick(64);

        // Long hold of KEY_AC: no auto-repeat, silent release.
        base = pcnt[KEY_AC];
        pressed[KEY_AC] = 1'b1;
        tick(1000);
        check_eq("ac_hold", pcnt[KEY_AC] - base, 1);
        pressed = '0;
        tick(100);
        check_eq("ac_release", pcnt[KEY_AC] - base, 1);
        check_eq("total_pulses", total, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
